// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUT-RAM primitive tests: checker state encoding,
// default blink half-periods and the expected-data pattern.
package lutram_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } chk_state_t;

    localparam logic [31:0] BLINK_SLOW_DEFAULT = 32'd49_999_999;
    localparam logic [31:0] BLINK_FAST_DEFAULT = 32'd9_999_999;

    // The write pattern depends only on the address LSB, so callers pass addr[0].
    function automatic logic exp_bit(input logic addr, input logic invert);
        return addr ^ invert;
    endfunction

endpackage

// File: rtl/blink_gen.sv
// LED blink-code generator: solid-on, or a square wave whose half-period is
// selected between a slow and a fast value.
module blink_gen #(
    parameter logic [31:0] HALF_SLOW = 32'd49_999_999,
    parameter logic [31:0] HALF_FAST = 32'd9_999_999
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_solid,
    input  logic i_en,
    input  logic i_period_sel,
    output logic o_led
);

    logic [31:0] r_cnt;
    logic        r_led;
    logic [31:0] w_half;

    assign w_half = i_period_sel ? HALF_FAST : HALF_SLOW;

    // Toggling when the counter reaches w_half gives a half-period of w_half+1 cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 32'd0;
            r_led <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= 32'd0;
            r_led <= i_solid;
        end else if (i_solid) begin
            r_cnt <= 32'd0;
            r_led <= 1'b1;
        end else if (i_en) begin
            if (r_cnt == w_half) begin
                r_cnt <= 32'd0;
                r_led <= ~r_led;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end else begin
            r_cnt <= 32'd0;
            r_led <= 1'b0;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/lutram_readback_checker.sv
// Readback checker for the LUT-RAM tests: compares the read stream against the
// write pattern, counts mismatches, latches the first bad address, blinks a verdict.
module lutram_readback_checker
    import lutram_test_pkg::*;
#(
    parameter int          A_WIDTH    = 6,
    parameter logic        INVERT     = 1'b0,
    parameter logic [31:0] BLINK_SLOW = BLINK_SLOW_DEFAULT,
    parameter logic [31:0] BLINK_FAST = BLINK_FAST_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               valid_i,
    input  logic [A_WIDTH-1:0] addr_i,
    input  logic               q_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [A_WIDTH:0]   err_count_o,
    output logic [A_WIDTH-1:0] first_err_addr_o,
    output logic               led_o
);

    localparam logic [A_WIDTH-1:0] ADDR_ONE = A_WIDTH'(1);
    localparam logic [A_WIDTH:0]   ERR_ONE  = (A_WIDTH + 1)'(1);

    chk_state_t         r_state;
    chk_state_t         w_next_state;
    logic [A_WIDTH-1:0] r_exp_addr;
    logic [A_WIDTH:0]   r_err_count;
    logic [A_WIDTH-1:0] r_first_err_addr;
    logic               r_seen_err;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               w_accept;
    logic               w_mismatch;
    logic               w_last;

    // A restart wins over a coincident sample, which is then dropped.
    assign w_accept   = (r_state == ST_CHECK) && valid_i && !start_i;
    assign w_mismatch = (q_i != exp_bit(addr_i[0], INVERT)) || (addr_i != r_exp_addr);
    assign w_last     = w_accept && (r_exp_addr == {A_WIDTH{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (start_i) begin
            w_next_state = ST_CHECK;
        end else if (w_last) begin
            w_next_state = (r_seen_err || w_mismatch) ? ST_FAIL : ST_PASS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_exp_addr       <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_seen_err       <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_CHECK);
            r_done <= (w_next_state == ST_PASS) || (w_next_state == ST_FAIL);
            r_pass <= (w_next_state == ST_PASS);
            if (start_i) begin
                r_exp_addr       <= '0;
                r_err_count      <= '0;
                r_first_err_addr <= '0;
                r_seen_err       <= 1'b0;
            end else if (w_accept) begin
                r_exp_addr <= r_exp_addr + ADDR_ONE;
                if (w_mismatch) begin
                    if (r_err_count != {(A_WIDTH + 1){1'b1}}) r_err_count <= r_err_count + ERR_ONE;
                    if (!r_seen_err) begin
                        r_first_err_addr <= addr_i;
                        r_seen_err       <= 1'b1;
                    end
                end
            end
        end
    end

    // Driven from the next state so the LED register lines up with the state register.
    blink_gen #(
        .HALF_SLOW (BLINK_SLOW),
        .HALF_FAST (BLINK_FAST)
    ) u_blink (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_clr        (w_next_state != r_state),
        .i_solid      (w_next_state == ST_CHECK),
        .i_en         ((w_next_state == ST_PASS) || (w_next_state == ST_FAIL)),
        .i_period_sel (w_next_state == ST_FAIL),
        .o_led        (led_o)
    );

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign pass_o           = r_pass;
    assign err_count_o      = r_err_count;
    assign first_err_addr_o = r_first_err_addr;

endmodule

// File: doc/lutram_readback_checker.md
# lutram_readback_checker

Self-checking readback stage for the LUT-RAM primitive tests. It sits directly downstream of a RAM64X1S-style test harness, in the 200 MHz `clk` domain. It consumes the read-phase data/address stream, compares each sample against the write pattern, counts mismatches and records the first failing address. It then drives a board LED with a blink code: slow blink = pass, fast blink = fail. This makes a hardware run self-reporting instead of requiring a scope on `q_o`.

## Interface
Parameters:
- `A_WIDTH`, 6, RAM address width; one pass covers 2**A_WIDTH samples.
- `INVERT`, 1'b0, expected data = `addr[0] ^ INVERT`.
- `BLINK_SLOW`, 32'd49_999_999, half-period in `clk_i` cycles for the pass blink.
- `BLINK_FAST`, 32'd9_999_999, half-period in `clk_i` cycles for the fail blink.

Ports:
- `clk_i`  in  1  single clock; all logic on posedge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  one-cycle pulse; arms a new check pass.
- `valid_i`  in  1  one-cycle pulse; `addr_i`/`q_i` hold a read sample.
- `addr_i`  in  A_WIDTH  address of the sample.
- `q_i`  in  1  RAM read data for `addr_i`.
- `busy_o`  out  1  high in CHECK.
- `done_o`  out  1  high in PASS or FAIL.
- `pass_o`  out  1  high only in PASS.
- `err_count_o`  out  A_WIDTH+1  saturating mismatch count.
- `first_err_addr_o`  out  A_WIDTH  address of the first mismatch.
- `led_o`  out  1  blink-code output.

## Operation
- FSM states: IDLE, CHECK, PASS, FAIL. State encoding goes in the package.
- IDLE to CHECK on `start_i`.
- Entering CHECK: clears `exp_addr`, `err_count`, `first_err_addr` and the `seen_err` flag.
- `start_i` in any non-reset state restarts CHECK with a full clear. `start_i` takes priority over a coincident `valid_i`; that sample is discarded.
- In CHECK, on each `valid_i`, the sample is a mismatch if either holds:
  - `q_i != (addr_i[0] ^ INVERT)`
  - `addr_i != exp_addr` (sequence error)
- On a mismatch:
  - `err_count` increments, saturating at all-ones (2**(A_WIDTH+1)-1).
  - If `seen_err` is 0, `first_err_addr <= addr_i` and `seen_err <= 1`.
- `exp_addr` increments on every accepted `valid_i` and wraps modulo 2**A_WIDTH.
- Pass ends on the `valid_i` where `exp_addr == 2**A_WIDTH-1`. The next state is PASS if there were no mismatches, including that final sample; otherwise FAIL.
- PASS and FAIL hold until `start_i` or `rst_i`. `valid_i` is ignored outside CHECK.
- LED behaviour:
  - IDLE: `led_o` = 0.
  - CHECK: `led_o` = 1 (solid).
  - PASS or FAIL: `led_o` toggles every `BLINK_SLOW+1` or `BLINK_FAST+1` cycles respectively, using a 32-bit counter.
  - The blink counter and `led_o` clear to 0 on every state change.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `busy_o`, `done_o`, `pass_o`, `led_o` = 0; `err_count_o` = 0; `first_err_addr_o` = 0.
- `err_count_o` and `first_err_addr_o` update one cycle after the `valid_i` cycle.
- `done_o` and `pass_o` assert one cycle after the final `valid_i`. `busy_o` falls in the same cycle.
- `busy_o` rises one cycle after `start_i`.
- Upstream spaces `valid_i` at least 2 cycles apart (divided-clock rate). Back-to-back `valid_i` is still handled correctly, one sample per cycle.
- `rst_i` mid-CHECK: state is IDLE on the next edge and all counts clear. No `done_o` is produced.
- `first_err_addr_o` is meaningful only when `err_count_o != 0`.

## Structure
- Package `lutram_test_pkg` holds:
  - checker state localparams (IDLE=2'd0, CHECK=2'd1, PASS=2'd2, FAIL=2'd3);
  - the default blink constants;
  - the expected-data function `exp_bit(addr, invert)`, shared with the stimulus FSMs.
- Sub-module `blink_gen`: 32-bit half-period counter with a `period_sel` input and a `clr` input, producing `led_o`.
- The comparator/FSM stays in the top module.

## Test plan
- Clean pass: `start_i`, then 64 `valid_i` with `addr_i` = 0..63 and `q_i` = `addr_i[0]`. Expect `done_o` = 1, `pass_o` = 1, `err_count_o` = 0 one cycle after sample 63, and `led_o` toggles every `BLINK_SLOW+1` cycles (small values in the bench).
- Single bit flip: as clean pass but `q_i` inverted at `addr_i` = 37. Expect FAIL, `err_count_o` = 1, `first_err_addr_o` = 37, fast blink.
- Sequence error: skip address 10 (send 9, 11, ...). Expect the first mismatch recorded at address 11, FAIL at the end of the pass, and `err_count_o` ≥ 1.
- Saturation: `A_WIDTH` = 2, `INVERT` = 1 with a stream that matches `INVERT` = 0, repeated with `start_i` omitted. Expect `err_count_o` = 4 after the pass, and no wrap on further errors in a forced long run.
- Restart priority: `start_i` and `valid_i` in the same cycle mid-pass. Expect counts cleared, that sample ignored, and `exp_addr` = 0.
- Reset mid-operation: `rst_i` after 20 samples. Expect IDLE, all outputs 0 next cycle, and no `done_o` afterwards without a new `start_i`.
